// File: rtl/div_unit.sv
// Iterative RV32M divider: one radix-2 restoring step per cycle, with
// divide-by-zero and signed-overflow results produced without iterating.
module div_unit #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [Width-1:0] result_o
);

  localparam int CntW = $clog2(Width);
  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};
  localparam logic [CntW-1:0]  LastCnt = CntW'(Width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             rem_sel_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] dvd_q;
  logic [Width-1:0] dvs_q;
  logic [Width-1:0] rem_q;
  logic [Width-1:0] quot_q;
  logic [Width-1:0] result_q;

  logic             a_neg_s;
  logic             b_neg_s;
  logic             special_s;
  logic [Width-1:0] a_mag_s;
  logic [Width-1:0] b_mag_s;
  logic [Width-1:0] special_res_s;
  logic [Width:0]   rem_ext_s;
  logic [Width:0]   diff_s;
  logic             quot_bit_s;
  logic [Width-1:0] rem_d;
  logic [Width-1:0] quot_d;
  logic [Width-1:0] final_res_s;

  // Operand conditioning and special-case detection for a new request.
  always_comb begin
    a_neg_s       = ~op_i[0] & operand_a_i[Width-1];
    b_neg_s       = ~op_i[0] & operand_b_i[Width-1];
    a_mag_s       = a_neg_s ? -operand_a_i : operand_a_i;
    b_mag_s       = b_neg_s ? -operand_b_i : operand_b_i;
    special_s     = 1'b0;
    special_res_s = '0;
    if (operand_b_i == '0) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? operand_a_i : '1;
    end else if (~op_i[0] && operand_a_i == MinNeg && operand_b_i == '1) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? '0 : operand_a_i;
    end else begin
      special_s     = 1'b0;
      special_res_s = '0;
    end
  end

  // One restoring step; the compare/subtract is Width+1 bits so large unsigned
  // divisors cannot overflow the partial remainder.
  always_comb begin
    rem_ext_s   = {rem_q, dvd_q[Width-1]};
    diff_s      = rem_ext_s - {1'b0, dvs_q};
    quot_bit_s  = ~diff_s[Width];
    rem_d       = quot_bit_s ? diff_s[Width-1:0] : rem_ext_s[Width-1:0];
    quot_d      = {quot_q[Width-2:0], quot_bit_s};
    final_res_s = rem_sel_q ? (neg_rem_q ? -rem_d : rem_d)
                            : (neg_quot_q ? -quot_d : quot_d);
  end

  assign busy_o   = (state_q == CALC) || (state_q == DONE);
  assign valid_o  = (state_q == DONE) && !flush_i;
  assign result_o = result_q;

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      count_q    <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !flush_i) begin
            rem_sel_q <= op_i[1];
            if (special_s) begin
              result_q <= special_res_s;
              state_q  <= DONE;
            end else begin
              dvd_q      <= a_mag_s;
              dvs_q      <= b_mag_s;
              neg_quot_q <= a_neg_s ^ b_neg_s;
              neg_rem_q  <= a_neg_s;
              rem_q      <= '0;
              quot_q     <= '0;
              count_q    <= '0;
              state_q    <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvd_q   <= {dvd_q[Width-2:0], 1'b0};
            count_q <= count_q + CntW'(1);
            if (count_q == LastCnt) begin
              result_q <= final_res_s;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
